// File: rtl/frame_deframer_if.sv
// Byte-stream receive side and assembled-frame delivery side of the deframer.
// The master is the line receiver plus frame consumer; the slave is the deframer.
interface frame_deframer_if #(
    parameter int FRAME_SIZE = 599
);
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic [0:FRAME_SIZE] frame_out;
    logic                frame_valid;
    logic                err_valid;
    logic [1:0]          err_code;
    logic                rx_busy;

    modport master (
        output rx_data,
        output rx_valid,
        input  frame_out,
        input  frame_valid,
        input  err_valid,
        input  err_code,
        input  rx_busy
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output frame_out,
        output frame_valid,
        output err_valid,
        output err_code,
        output rx_busy
    );
endinterface

// File: rtl/frame_deframer.sv
// Strips START/END delimiters, undoes ESC byte-stuffing and assembles a fixed-length
// frame; malformed frames are dropped with a one-cycle error strobe.
module frame_deframer #(
    parameter int          DATA_SIZE     = 64,
    parameter int          PREAMBLE_SIZE = 7,
    parameter int          CRC_SIZE      = 4,
    parameter logic [7:0]  FRAME_START   = 8'h06,
    parameter logic [7:0]  FRAME_END     = 8'h07,
    parameter logic [7:0]  ESC_VAL       = 8'h14,
    parameter logic [7:0]  ESC_XOR       = 8'h20
) (
    input  logic               clk,
    input  logic               rst_n,
    frame_deframer_if.slave    bus
);
    localparam int FRAME_BYTES = PREAMBLE_SIZE + DATA_SIZE + CRC_SIZE;
    localparam int FRAME_SIZE  = FRAME_BYTES * 8 - 1;
    localparam logic [6:0] FRAME_BYTES_C = 7'(FRAME_BYTES);

    localparam logic [1:0] ERR_LEN    = 2'b01;
    localparam logic [1:0] ERR_ESC    = 2'b10;
    localparam logic [1:0] ERR_RESYNC = 2'b11;

    typedef enum logic [1:0] {
        ST_HUNT = 2'b00,
        ST_RECV = 2'b01,
        ST_ESC  = 2'b10
    } state_t;

    state_t              state_r, state_next_s;
    logic [6:0]          count_r, count_next_s;
    logic [0:FRAME_SIZE] asm_r, asm_next_s;
    logic [0:FRAME_SIZE] frame_out_r, frame_out_next_s;
    logic                frame_valid_r, frame_valid_next_s;
    logic                err_valid_r, err_valid_next_s;
    logic [1:0]          err_code_r, err_code_next_s;
    logic                rx_busy_r;
    logic                store_req_s;
    logic [7:0]          store_data_s;
    logic [9:0]          byte_base_s;

    assign byte_base_s = {count_r, 3'b000};

    // Byte to be stored: escaped bytes arrive XOR-masked and are restored here.
    always_comb begin
        if (state_r == ST_ESC) begin
            store_data_s = bus.rx_data ^ ESC_XOR;
        end else begin
            store_data_s = bus.rx_data;
        end
    end

    // Next-state, assembly and strobe decode for one accepted byte.
    always_comb begin
        state_next_s       = state_r;
        count_next_s       = count_r;
        asm_next_s         = asm_r;
        frame_out_next_s   = frame_out_r;
        frame_valid_next_s = 1'b0;
        err_valid_next_s   = 1'b0;
        err_code_next_s    = err_code_r;
        store_req_s        = 1'b0;

        if (bus.rx_valid) begin
            case (state_r)
                ST_HUNT: begin
                    if (bus.rx_data == FRAME_START) begin
                        state_next_s = ST_RECV;
                        count_next_s = 7'd0;
                    end else begin
                        state_next_s = ST_HUNT;
                    end
                end
                ST_RECV: begin
                    if (bus.rx_data == FRAME_START) begin
                        err_valid_next_s = 1'b1;
                        err_code_next_s  = ERR_RESYNC;
                        count_next_s     = 7'd0;
                        state_next_s     = ST_RECV;
                    end else if (bus.rx_data == FRAME_END) begin
                        if (count_r == FRAME_BYTES_C) begin
                            frame_out_next_s   = asm_r;
                            frame_valid_next_s = 1'b1;
                        end else begin
                            err_valid_next_s = 1'b1;
                            err_code_next_s  = ERR_LEN;
                        end
                        state_next_s = ST_HUNT;
                    end else if (bus.rx_data == ESC_VAL) begin
                        state_next_s = ST_ESC;
                    end else begin
                        store_req_s = 1'b1;
                    end
                end
                ST_ESC: begin
                    if (bus.rx_data == FRAME_START) begin
                        // An escaped START is still treated as the start of a new frame.
                        err_valid_next_s = 1'b1;
                        err_code_next_s  = ERR_ESC;
                        count_next_s     = 7'd0;
                        state_next_s     = ST_RECV;
                    end else if (bus.rx_data == FRAME_END) begin
                        err_valid_next_s = 1'b1;
                        err_code_next_s  = ERR_ESC;
                        state_next_s     = ST_HUNT;
                    end else begin
                        store_req_s = 1'b1;
                    end
                end
                default: begin
                    state_next_s = ST_HUNT;
                    count_next_s = 7'd0;
                end
            endcase

            if (store_req_s) begin
                if (count_r < FRAME_BYTES_C) begin
                    asm_next_s[byte_base_s +: 8] = store_data_s;
                    count_next_s                 = count_r + 7'd1;
                    state_next_s                 = ST_RECV;
                end else begin
                    err_valid_next_s = 1'b1;
                    err_code_next_s  = ERR_LEN;
                    state_next_s     = ST_HUNT;
                end
            end else begin
                store_req_s = 1'b0;
            end
        end else begin
            state_next_s = state_r;
        end
    end

    // State, assembly buffer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_HUNT;
            count_r       <= 7'd0;
            asm_r         <= '0;
            frame_out_r   <= '0;
            frame_valid_r <= 1'b0;
            err_valid_r   <= 1'b0;
            err_code_r    <= 2'b00;
            rx_busy_r     <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            count_r       <= count_next_s;
            asm_r         <= asm_next_s;
            frame_out_r   <= frame_out_next_s;
            frame_valid_r <= frame_valid_next_s;
            err_valid_r   <= err_valid_next_s;
            err_code_r    <= err_code_next_s;
            rx_busy_r     <= (state_next_s != ST_HUNT);
        end
    end

    assign bus.frame_out   = frame_out_r;
    assign bus.frame_valid = frame_valid_r;
    assign bus.err_valid   = err_valid_r;
    assign bus.err_code    = err_code_r;
    assign bus.rx_busy     = rx_busy_r;
endmodule

// File: tb/tb_frame_deframer.sv
// Directed bench for frame_deframer: a table of whole-frame vectors plus
// hand-written sequences for resync, escape errors and asynchronous reset.
module tb_frame_deframer;
    localparam int FRAME_BYTES = 75;
    localparam int FRAME_SIZE  = FRAME_BYTES * 8 - 1;

    logic clk;
    logic rst_n;

    frame_deframer_if #(.FRAME_SIZE(FRAME_SIZE)) bus ();

    frame_deframer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         n_bytes;
        logic [7:0] first;
        logic       exp_fv;
        logic       exp_ev;
        logic [1:0] exp_code;
        bit         gaps;
    } vec_t;

    vec_t vecs [8];

    int tests_run;
    int tests_failed;
    int n_fv;
    int n_ev;
    int n_both;
    int n_idle_strobe;
    logic [1:0] last_code;
    bit gap_en;
    logic [0:FRAME_SIZE] exp_frame;
    logic [0:FRAME_SIZE] prev_frame;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_frame(input string name, input logic [0:FRAME_SIZE] exp);
        tests_run++;
        if (bus.frame_out !== exp) begin
            tests_failed++;
            $display("FAIL %s: frame_out got %h expected %h", name, bus.frame_out, exp);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.rx_valid = 1'b0;
        @(posedge clk);
        #1;
        if (bus.frame_valid || bus.err_valid) n_idle_strobe++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        if (gap_en) idle_cycle();
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        if (bus.frame_valid) n_fv++;
        if (bus.err_valid) begin
            n_ev++;
            last_code = bus.err_code;
        end
        if (bus.frame_valid && bus.err_valid) n_both++;
    endtask

    // Data bytes that collide with delimiters or the escape marker go out stuffed.
    task automatic send_data(input logic [7:0] b);
        if (b == 8'h06 || b == 8'h07 || b == 8'h14) begin
            send_byte(8'h14);
            send_byte(b ^ 8'h20);
        end else begin
            send_byte(b);
        end
    endtask

    task automatic clear_counts();
        n_fv      = 0;
        n_ev      = 0;
        last_code = 2'b00;
    endtask

    task automatic build_exp(input logic [7:0] first);
        logic [7:0] v;
        for (int i = 0; i < FRAME_BYTES; i++) begin
            v = first + 8'(i);
            exp_frame[i*8 +: 8] = v;
        end
    endtask

    task automatic run_vec(input vec_t v);
        clear_counts();
        gap_en = v.gaps;
        send_byte(8'h06);
        for (int i = 0; i < v.n_bytes; i++) send_data(v.first + 8'(i));
        send_byte(8'h07);
        gap_en = 1'b0;
        idle_cycle();
        check({v.name, "_fv"}, 32'(n_fv), {31'd0, v.exp_fv});
        check({v.name, "_ev"}, 32'(n_ev), {31'd0, v.exp_ev});
        if (v.exp_ev) check({v.name, "_code"}, 32'(last_code), 32'(v.exp_code));
        if (v.exp_fv) begin
            build_exp(v.first);
            prev_frame = exp_frame;
        end
        check_frame({v.name, "_frame"}, prev_frame);
        check({v.name, "_busy"}, 32'(bus.rx_busy), 32'd0);
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        n_both        = 0;
        n_idle_strobe = 0;
        gap_en        = 1'b0;
        prev_frame    = '0;
        clear_counts();

        vecs[0] = '{"clean",    75, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0};
        vecs[1] = '{"esc_at10", 75, 8'hFC, 1'b1, 1'b0, 2'b00, 1'b0};
        vecs[2] = '{"gapped",   75, 8'h80, 1'b1, 1'b0, 2'b00, 1'b1};
        vecs[3] = '{"short74",  74, 8'h30, 1'b0, 1'b1, 2'b01, 1'b0};
        vecs[4] = '{"empty",     0, 8'h30, 1'b0, 1'b1, 2'b01, 1'b0};
        vecs[5] = '{"long76",   76, 8'h30, 1'b0, 1'b1, 2'b01, 1'b0};
        vecs[6] = '{"long80",   80, 8'h30, 1'b0, 1'b1, 2'b01, 1'b0};
        vecs[7] = '{"wrap",     75, 8'hF0, 1'b1, 1'b0, 2'b00, 1'b0};

        rst_n        = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fv", 32'(bus.frame_valid), 32'd0);
        check("rst_ev", 32'(bus.err_valid), 32'd0);
        check("rst_code", 32'(bus.err_code), 32'd0);
        check("rst_busy", 32'(bus.rx_busy), 32'd0);
        check_frame("rst_frame", prev_frame);
        @(negedge clk);
        rst_n = 1'b1;

        // Junk outside a frame is silently discarded.
        clear_counts();
        send_byte(8'h14);
        send_byte(8'h07);
        send_byte(8'h41);
        check("hunt_ev", 32'(n_ev), 32'd0);
        check("hunt_busy", 32'(bus.rx_busy), 32'd0);

        for (int k = 0; k < 8; k++) begin
            run_vec(vecs[k]);
            if (k == 0) begin
                check("clean_b0", 32'(bus.frame_out[0:7]), 32'h00);
                check("clean_b74", 32'(bus.frame_out[592:599]), 32'h4A);
            end
            if (k == 1) check("esc_b10", 32'(bus.frame_out[80:87]), 32'h06);
        end

        // Resync: a second START mid-frame restarts reception.
        clear_counts();
        send_byte(8'h06);
        for (int i = 0; i < 20; i++) send_data(8'h40 + 8'(i));
        check("pre_resync_busy", 32'(bus.rx_busy), 32'd1);
        send_byte(8'h06);
        check("resync_ev", 32'(n_ev), 32'd1);
        check("resync_code", 32'(last_code), 32'd3);
        check("resync_busy", 32'(bus.rx_busy), 32'd1);
        clear_counts();
        for (int i = 0; i < 75; i++) send_data(8'h11 + 8'(i));
        send_byte(8'h07);
        check("resync_fv", 32'(n_fv), 32'd1);
        check("resync_ev2", 32'(n_ev), 32'd0);
        build_exp(8'h11);
        prev_frame = exp_frame;
        check_frame("resync_frame", prev_frame);

        // ESC followed by START: escape error, reception restarts.
        clear_counts();
        send_byte(8'h06);
        for (int i = 0; i < 5; i++) send_data(8'h50 + 8'(i));
        send_byte(8'h14);
        send_byte(8'h06);
        check("esc06_code", 32'(last_code), 32'd2);
        check("esc06_busy", 32'(bus.rx_busy), 32'd1);
        for (int i = 0; i < 75; i++) send_data(8'h21 + 8'(i));
        send_byte(8'h07);
        check("esc06_ev", 32'(n_ev), 32'd1);
        check("esc06_fv", 32'(n_fv), 32'd1);
        build_exp(8'h21);
        prev_frame = exp_frame;
        check_frame("esc06_frame", prev_frame);

        // ESC followed by END: escape error, back to hunting.
        clear_counts();
        send_byte(8'h06);
        for (int i = 0; i < 3; i++) send_data(8'h60 + 8'(i));
        send_byte(8'h14);
        send_byte(8'h07);
        check("esc07_ev", 32'(n_ev), 32'd1);
        check("esc07_code", 32'(last_code), 32'd2);
        check("esc07_busy", 32'(bus.rx_busy), 32'd0);
        check_frame("esc07_frame", prev_frame);

        // Escaped 76th byte overflows exactly like a plain one.
        clear_counts();
        send_byte(8'h06);
        for (int i = 0; i < 75; i++) send_data(8'h30 + 8'(i));
        send_byte(8'h14);
        send_byte(8'h41);
        check("escovf_ev", 32'(n_ev), 32'd1);
        check("escovf_code", 32'(last_code), 32'd1);
        check("escovf_busy", 32'(bus.rx_busy), 32'd0);
        send_byte(8'h07);
        check("escovf_fv", 32'(n_fv), 32'd0);

        // Asynchronous reset between clock edges, mid-frame.
        send_byte(8'h06);
        for (int i = 0; i < 30; i++) send_data(8'h70 + 8'(i));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        prev_frame = '0;
        check("arst_busy", 32'(bus.rx_busy), 32'd0);
        check("arst_ev", 32'(bus.err_valid), 32'd0);
        check("arst_code", 32'(bus.err_code), 32'd0);
        check_frame("arst_frame", prev_frame);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[0]);

        check("never_both", 32'(n_both), 32'd0);
        check("idle_strobes", 32'(n_idle_strobe), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
